// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment path: request sizes, FSM states
// and the per-size byte-lane masks.
package store_pkg;

  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SB  = 2'b01;
  localparam logic [1:0] ST_SH  = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_e;

  // The reserved encoding behaves as a full-word store.
  function automatic logic [3:0] size_mask(input logic [1:0] sel);
    logic [3:0] m;
    case (sel)
      ST_SB:   m = MASK_B;
      ST_SH:   m = MASK_H;
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Core-side store request and memory-side write beat of the store align unit.
interface store_align_unit_if;
  // Both channels use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; once valid rises, the producer holds
  // valid and its payload unchanged until that transfer (reset excepted), and
  // ready may be driven independently of valid.
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_sel;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  logic        done;
  logic        split;

  modport master (
    output req_valid, req_addr, req_data, req_sel, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, split
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_sel, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, split
  );
endinterface

// File: rtl/store_align_unit_lane_shift.sv
// Combinational lane steering: moves right-justified store data into its byte
// lanes across a two-word window and produces the matching enables.
module store_lane_shift
  import store_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  sel,
  input  logic [1:0]  offset,
  output logic [7:0]  enable,
  output logic [63:0] shifted
);

  logic [3:0]  mask;
  logic [31:0] keep;

  always_comb begin
    mask = size_mask(sel);
    // Bytes above the store size are cleared so disabled lanes stay zero.
    keep    = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    enable  = {4'b0000, mask} << offset;
    shifted = {32'h0000_0000, data & keep} << {offset, 3'b000};
  end

endmodule

// File: rtl/store_align_unit.sv
// Store request to word-aligned memory write beats; stores that straddle a
// word boundary are issued as two consecutive beats.
module store_align_unit
  import store_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  store_align_unit_if.slave   bus,
  output state_e              dbg_state
);

  state_e      state_q, state_d;
  logic [29:0] word_q;
  logic [7:0]  en_q;
  logic [63:0] data_q;
  logic        split_q;
  logic        done_q;

  logic [7:0]  en_c;
  logic [63:0] data_c;

  logic        req_ready_c;
  logic        mem_valid_c;
  logic [31:0] mem_addr_c;
  logic [31:0] mem_wdata_c;
  logic [3:0]  mem_be_c;

  logic        accept;
  logic        beat_hs;
  logic        final_hs;

  store_lane_shift u_lane_shift (
    .data    (bus.req_data),
    .sel     (bus.req_sel),
    .offset  (bus.req_addr[1:0]),
    .enable  (en_c),
    .shifted (data_c)
  );

  assign accept   = bus.req_valid & req_ready_c;
  assign beat_hs  = mem_valid_c & bus.mem_ready;
  assign final_hs = beat_hs & ((state_q == BEAT1) | ((state_q == BEAT0) & ~split_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BEAT0;
      BEAT0:   if (bus.mem_ready) state_d = split_q ? BEAT1 : IDLE;
      BEAT1:   if (bus.mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are zero outside a beat so idle and reset look identical.
  always_comb begin
    req_ready_c = 1'b0;
    mem_valid_c = 1'b0;
    mem_addr_c  = 32'h0000_0000;
    mem_wdata_c = 32'h0000_0000;
    mem_be_c    = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
      end
      BEAT0: begin
        mem_valid_c = 1'b1;
        mem_addr_c  = {word_q, 2'b00};
        mem_wdata_c = data_q[31:0];
        mem_be_c    = en_q[3:0];
      end
      BEAT1: begin
        mem_valid_c = 1'b1;
        // 30-bit increment wraps the top word back to address zero.
        mem_addr_c  = {word_q + 30'd1, 2'b00};
        mem_wdata_c = data_q[63:32];
        mem_be_c    = en_q[7:4];
      end
      default: begin
        req_ready_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= 30'h0;
      en_q    <= 8'h00;
      data_q  <= 64'h0;
      split_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= final_hs;
      if (accept) begin
        word_q  <= bus.req_addr[31:2];
        en_q    <= en_c;
        data_q  <= data_c;
        split_q <= |en_c[7:4];
      end else if (final_hs) begin
        split_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.mem_valid = mem_valid_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_be    = mem_be_c;
  assign bus.done      = done_q;
  assign bus.split     = split_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: expected beats are queued at issue
// time and a negedge monitor pops and compares every accepted beat.
module tb_store_align_unit;
  import store_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_e dbg_state;

  store_align_unit_if bus ();

  store_align_unit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  // {addr[31:0], wdata[31:0], be[3:0], split}
  logic [68:0] exp_q[$];

  function automatic logic [68:0] beat(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] be, input logic sp);
    return {a, d, be, sp};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; the request is accepted
  // on the following edge, and the task returns 1 unit after that edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sel);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_sel   = sel;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = 32'hFFFF_FFFF;
  endtask

  // Counts edges until done is seen; 20 means it never arrived.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done === 1'b1) return;
    end
  endtask

  // Scoreboard monitor: a beat is taken on the next edge when valid & ready.
  initial begin
    logic [68:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.mem_valid === 1'b1 && bus.mem_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got addr 0x%0h be %b, expected no beat",
                   bus.mem_addr, bus.mem_be);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr",  bus.mem_addr,  e[68:37]);
          check("beat_wdata", bus.mem_wdata, e[36:5]);
          check("beat_be",    bus.mem_be,    e[4:1]);
          check("beat_split", bus.split,     e[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_data  = 32'h0;
    bus.req_sel   = ST_SW;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_mem_addr",  bus.mem_addr,  32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_be",    bus.mem_be,    4'h0);
    check("rst_done",      bus.done,      1'b0);
    check("rst_split",     bus.split,     1'b0);
    check("rst_state",     dbg_state,     IDLE);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Aligned sw: done on the 1st edge after the accept edge (cycle N+2).
    exp_q.push_back(beat(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b0));
    issue(32'h0000_0100, 32'hDEAD_BEEF, ST_SW);
    check("sw_split",      bus.split,     1'b0);
    check("sw_mem_valid",  bus.mem_valid, 1'b1);
    check("sw_req_ready",  bus.req_ready, 1'b0);
    wait_done(n);
    check("sw_done_lat", n, 1);
    @(posedge clk);
    #1;
    check("sw_done_pulse", bus.done, 1'b0);

    // sb at offset 3; upper data bits are garbage and must not leak.
    exp_q.push_back(beat(32'h0000_0200, 32'hA500_0000, 4'b1000, 1'b0));
    issue(32'h0000_0203, 32'h1234_56A5, ST_SB);
    wait_done(n);
    check("sb_done_lat", n, 1);

    // sh straddling a word: two beats, done one edge later (cycle N+3).
    exp_q.push_back(beat(32'h0000_0300, 32'h3400_0000, 4'b1000, 1'b1));
    exp_q.push_back(beat(32'h0000_0304, 32'h0000_0012, 4'b0001, 1'b1));
    issue(32'h0000_0303, 32'h0000_1234, ST_SH);
    check("sh_split", bus.split, 1'b1);
    wait_done(n);
    check("sh_done_lat", n, 2);
    check("sh_split_clear", bus.split, 1'b0);

    // sw at the top of the address space wraps beat 1 to address 0.
    exp_q.push_back(beat(32'hFFFF_FFFC, 32'h3344_0000, 4'b1100, 1'b1));
    exp_q.push_back(beat(32'h0000_0000, 32'h0000_1122, 4'b0011, 1'b1));
    issue(32'hFFFF_FFFE, 32'h1122_3344, ST_SW);
    wait_done(n);
    check("wrap_done_lat", n, 2);

    // Reserved size acts as sw: offset 1 splits 3 + 1 bytes.
    exp_q.push_back(beat(32'h0000_0080, 32'hBBCC_DD00, 4'b1110, 1'b1));
    exp_q.push_back(beat(32'h0000_0084, 32'h0000_00AA, 4'b0001, 1'b1));
    issue(32'h0000_0081, 32'hAABB_CCDD, ST_RSV);
    wait_done(n);
    check("rsv_done_lat", n, 2);

    // Stall: three edges with mem_ready low, payload must hold.
    bus.mem_ready = 1'b0;
    exp_q.push_back(beat(32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 1'b0));
    issue(32'h0000_0040, 32'hCAFE_F00D, ST_SW);
    for (int i = 0; i < 4; i++) begin
      check("stall_addr",      bus.mem_addr,  32'h0000_0040);
      check("stall_wdata",     bus.mem_wdata, 32'hCAFE_F00D);
      check("stall_be",        bus.mem_be,    4'b1111);
      check("stall_mem_valid", bus.mem_valid, 1'b1);
      check("stall_req_ready", bus.req_ready, 1'b0);
      check("stall_done",      bus.done,      1'b0);
      if (i == 3) break;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    wait_done(n);
    check("stall_done_lat", n, 1);

    // Reset while beat 1 of a split store is stalled.
    exp_q.push_back(beat(32'h0000_0300, 32'h3400_0000, 4'b1000, 1'b1));
    issue(32'h0000_0303, 32'h0000_1234, ST_SH);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    check("mid_state",     dbg_state,     BEAT1);
    check("mid_mem_valid", bus.mem_valid, 1'b1);
    check("mid_addr",      bus.mem_addr,  32'h0000_0304);
    #2;
    reset = 1'b1;
    #1;
    check("arst_mem_valid", bus.mem_valid, 1'b0);
    check("arst_req_ready", bus.req_ready, 1'b1);
    check("arst_split",     bus.split,     1'b0);
    check("arst_mem_be",    bus.mem_be,    4'h0);
    check("arst_state",     dbg_state,     IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("arst_no_done", bus.done, 1'b0);
    end
    bus.mem_ready = 1'b1;
    exp_q.push_back(beat(32'h0000_0200, 32'h0000_5A00, 4'b0010, 1'b0));
    issue(32'h0000_0201, 32'h0000_005A, ST_SB);
    wait_done(n);
    check("post_rst_done_lat", n, 1);

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
